// File: rtl/piso_buf_256b_pkg.sv
// piso_buf_pkg: shared sizes, FSM state encoding and command codes for the 256 B PISO buffer
package piso_buf_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_DEPTH = 64;
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_SHIFT = 1'b1;
  typedef enum logic [2:0] {IDLE, LOAD, PRELOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/piso_buf_256b_if.sv
// piso_buf_256b_if: load, command and scan-out signals of the PISO buffer
interface piso_buf_256b_if import piso_buf_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) ();
  logic [WORD_W-1:0] pin;
  logic pin_val;
  logic pin_rdy;
  logic val_op;
  logic op;
  logic op_ack;
  logic op_commit;
  logic sout;
  logic scaning;
  modport master (
    output pin, pin_val, val_op, op,
    input pin_rdy, op_ack, op_commit, sout, scaning
  );
  modport slave (
    input pin, pin_val, val_op, op,
    output pin_rdy, op_ack, op_commit, sout, scaning
  );
endinterface

// File: rtl/piso_buf_256b_mem.sv
// piso_buf_256b_mem: DEPTH x WORD_W synchronous RAM, one write port, one read port, 1-cycle read latency
module piso_buf_256b_mem import piso_buf_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] waddr,
  input logic [WORD_W-1:0] wdata,
  input logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/piso_buf_256b.sv
// piso_buf_256b: 256 B buffer loaded word-parallel and scanned out bit-serially, LSB of word 0 first
module piso_buf_256b import piso_buf_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic reset,
  piso_buf_256b_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WORD_W);
  localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_B = BW'(WORD_W - 1);
  state_t state;
  logic [AW-1:0] waddr, raddr, rd_addr;
  logic [BW-1:0] bcnt;
  logic [WORD_W-1:0] sreg, rdata;
  logic we, pin_rdy, op_ack, op_commit, scaning;
  assign we = pin_rdy & bus.pin_val;
  // raddr tracks the word in sreg; the RAM always fetches the next one so reloads have no gap
  assign rd_addr = (state == IDLE) ? '0 : raddr + AW'(1);
  assign bus.pin_rdy = pin_rdy;
  assign bus.op_ack = op_ack;
  assign bus.op_commit = op_commit;
  assign bus.scaning = scaning;
  assign bus.sout = scaning & sreg[0];
  piso_buf_256b_mem #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(bus.pin),
    .raddr(rd_addr),
    .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      waddr <= '0;
      raddr <= '0;
      bcnt <= '0;
      sreg <= '0;
      pin_rdy <= 1'b0;
      op_ack <= 1'b0;
      op_commit <= 1'b0;
      scaning <= 1'b0;
    end else
      case (state)
        IDLE: begin
          op_ack <= 1'b1;
          if (bus.val_op && op_ack) begin
            op_ack <= 1'b0;
            if (bus.op == OP_SHIFT) begin
              raddr <= '0;
              bcnt <= '0;
              state <= PRELOAD;
            end else begin
              waddr <= '0;
              pin_rdy <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD:
          if (bus.pin_val) begin
            waddr <= waddr + AW'(1);
            if (waddr == LAST_W) begin
              pin_rdy <= 1'b0;
              op_commit <= 1'b1;
              state <= DONE;
            end
          end
        PRELOAD: begin
          sreg <= rdata;
          scaning <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          bcnt <= bcnt + BW'(1);
          sreg <= (bcnt == LAST_B) ? rdata : sreg >> 1;
          if (bcnt == LAST_B) raddr <= raddr + AW'(1);
          if (bcnt == LAST_B && raddr == LAST_W) begin
            scaning <= 1'b0;
            op_commit <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          op_commit <= 1'b0;
          op_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_piso_buf_256b.sv
// tb_piso_buf_256b: scoreboard bench for the PISO buffer; inputs change and outputs are sampled on negedge
module tb_piso_buf_256b;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] model [64];
  logic [31:0] ld [64];
  logic exp_q [$];
  piso_buf_256b_if #(.WORD_W(32)) bus ();
  piso_buf_256b #(.WORD_W(32), .DEPTH(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic do_op(input logic o);
    int k;
    k = 0;
    while (bus.op_ack !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (bus.op_ack !== 1'b1) begin
      fails++;
      $display("FAIL op_ack_wait: op_ack=%b required 1", bus.op_ack);
    end
    bus.val_op = 1'b1;
    bus.op = o;
    @(negedge clk);
    bus.val_op = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.val_op = 1'b1;
    bus.op = 1'b0;
    bus.pin_val = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.op_ack, bus.pin_rdy, bus.op_commit, bus.scaning, bus.sout} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outs: ack/rdy/commit/scan/sout=%b required 00000",
               {bus.op_ack, bus.pin_rdy, bus.op_commit, bus.scaning, bus.sout});
    end
    reset = 1'b1;
    bus.val_op = 1'b0;
    bus.pin_val = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.op_ack !== 1'b1 || bus.pin_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: op_ack=%b pin_rdy=%b required 1 0", bus.op_ack, bus.pin_rdy);
    end
  endtask

  task automatic test_load(input bit toggle);
    int i, cyc;
    logic v;
    do_op(1'b0);
    i = 0;
    cyc = 0;
    while (i < 64 && cyc < 400) begin
      tests++;
      if (bus.pin_rdy !== 1'b1 || bus.op_ack !== 1'b0 || bus.op_commit !== 1'b0) begin
        fails++;
        $display("FAIL load_cycle %0d: rdy=%b ack=%b commit=%b required 1 0 0",
                 cyc, bus.pin_rdy, bus.op_ack, bus.op_commit);
      end
      v = toggle ? logic'(cyc % 2 == 1) : 1'b1;
      bus.pin_val = v;
      bus.pin = ld[i];
      bus.val_op = (cyc == 10);
      bus.op = 1'b1;
      @(negedge clk);
      cyc++;
      if (v) begin
        model[i] = ld[i];
        i++;
      end
    end
    bus.pin_val = 1'b0;
    bus.val_op = 1'b0;
    tests++;
    if (cyc != (toggle ? 128 : 64)) begin
      fails++;
      $display("FAIL load_len: %0d cycles required %0d", cyc, toggle ? 128 : 64);
    end
    tests++;
    if (bus.op_commit !== 1'b1 || bus.pin_rdy !== 1'b0) begin
      fails++;
      $display("FAIL load_commit: commit=%b rdy=%b required 1 0", bus.op_commit, bus.pin_rdy);
    end
    @(negedge clk);
    tests++;
    if (bus.op_commit !== 1'b0 || bus.op_ack !== 1'b1) begin
      fails++;
      $display("FAIL load_idle: commit=%b ack=%b required 0 1", bus.op_commit, bus.op_ack);
    end
  endtask

  task automatic test_shift(input int abort_n);
    int n, bad;
    logic e;
    exp_q.delete();
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 32; b++) exp_q.push_back(model[w][b]);
    do_op(1'b1);
    tests++;
    if (bus.scaning !== 1'b0 || bus.sout !== 1'b0) begin
      fails++;
      $display("FAIL shift_preload: scan=%b sout=%b required 0 0", bus.scaning, bus.sout);
    end
    bad = 0;
    for (n = 0; n < 2048; n++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (bus.scaning !== 1'b1 || bus.sout !== e || bus.op_commit !== 1'b0) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL shift_bit n=%0d: scan=%b sout=%b commit=%b required 1 %b 0",
                   n, bus.scaning, bus.sout, bus.op_commit, e);
      end
      bus.val_op = (n == 500);
      bus.op = 1'b0;
      if (n == 500) begin
        tests++;
        if (bus.op_ack !== 1'b0) begin
          fails++;
          $display("FAIL shift_ack: op_ack=%b required 0", bus.op_ack);
        end
      end
      if (n == abort_n) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++;
        if (bus.scaning !== 1'b0 || bus.sout !== 1'b0 || bus.op_commit !== 1'b0) begin
          fails++;
          $display("FAIL shift_abort: scan=%b sout=%b commit=%b required 0 0 0",
                   bus.scaning, bus.sout, bus.op_commit);
        end
        @(negedge clk);
        return;
      end
    end
    bus.val_op = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.scaning !== 1'b0 || bus.sout !== 1'b0 || bus.op_commit !== 1'b1 || bus.pin_rdy !== 1'b0) begin
      fails++;
      $display("FAIL shift_done: scan=%b sout=%b commit=%b rdy=%b required 0 0 1 0",
               bus.scaning, bus.sout, bus.op_commit, bus.pin_rdy);
    end
    @(negedge clk);
    tests++;
    if (bus.op_commit !== 1'b0 || bus.op_ack !== 1'b1) begin
      fails++;
      $display("FAIL shift_idle: commit=%b ack=%b required 0 1", bus.op_commit, bus.op_ack);
    end
  endtask

  initial begin
    bus.pin = '0;
    bus.pin_val = 1'b0;
    bus.val_op = 1'b0;
    bus.op = 1'b0;
    test_reset();
    for (int i = 0; i < 64; i++) ld[i] = 32'(i);
    test_load(1'b0);
    test_shift(-1);
    for (int i = 0; i < 64; i++) ld[i] = 32'hA5A5_A5A5;
    test_load(1'b0);
    test_shift(-1);
    for (int i = 0; i < 64; i++) ld[i] = (i == 0) ? 32'h1 : (i == 1) ? 32'h8000_0000 : 32'h0;
    test_load(1'b1);
    test_shift(-1);
    for (int i = 0; i < 64; i++) ld[i] = $urandom;
    test_load(1'b1);
    test_shift(1000);
    test_shift(-1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_buf_256b.md
PISO_BUF_256B -- requirements
Module: piso_buf_256b

Interface
REQ-001 Parameter WORD_W, default 32: width of a buffered word.
REQ-002 Parameter DEPTH, default 64: number of words held (DEPTH*WORD_W = 2048 bits = 256 B).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low: state clears on a rising clk edge while reset=0.
REQ-005 pin  input  WORD_W  parallel load word.
REQ-006 pin_val  input  1  pin holds a valid word.
REQ-007 pin_rdy  output  1  block accepts a word this cycle.
REQ-008 val_op  input  1  command request valid.
REQ-009 op  input  1  command: 0 = LOAD, 1 = SHIFT.
REQ-010 op_ack  output  1  command accepted this cycle (val_op & op_ack = handshake).
REQ-011 op_commit  output  1  one-cycle pulse: accepted command finished.
REQ-012 sout  output  1  serial scan-chain data, LSB of word 0 first.
REQ-013 scaning  output  1  high exactly while sout carries valid buffer bits.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, PRELOAD, SHIFT, DONE.
REQ-015 op_ack SHALL be 1 in IDLE and 0 in all other states; val_op outside IDLE SHALL be ignored.
REQ-016 IDLE with val_op=1, op=0 SHALL clear the write address to 0 and go to LOAD next cycle.
REQ-017 IDLE with val_op=1, op=1 SHALL clear the read address and bit counter and go to PRELOAD.
REQ-018 In LOAD pin_rdy SHALL be 1; each cycle with pin_val=1 SHALL write pin to mem[waddr] and increment waddr.
REQ-019 The cycle writing word DEPTH-1 SHALL transition LOAD -> DONE; waddr wraps to 0, no further writes.
REQ-020 pin_rdy SHALL be 0 outside LOAD; pin_val outside LOAD SHALL have no effect.
REQ-021 PRELOAD SHALL last exactly one cycle, reading mem[0] into the shift register, then enter SHIFT.
REQ-022 On SHIFT cycle n (n = 0..DEPTH*WORD_W-1), sout SHALL equal bit (n mod WORD_W) of mem[n / WORD_W]; scaning SHALL be 1.
REQ-023 Word reloads SHALL be prefetched so sout has no gap between the last bit of a word and the first bit of the next.
REQ-024 After cycle n = DEPTH*WORD_W-1 (2047 default) SHALL transition SHIFT -> DONE.
REQ-025 DONE SHALL last one cycle with op_commit=1, then return to IDLE; op_commit SHALL be 0 in every other state.
REQ-026 sout SHALL be 0 whenever scaning=0.
REQ-027 Bit counter SHALL be log2(WORD_W) bits and word counters log2(DEPTH) bits, both wrapping modulo their range.
REQ-028 SHIFT without a prior LOAD SHALL shift out current memory contents unchanged; SHIFT SHALL NOT modify memory.

Reset
REQ-029 Reset SHALL force state IDLE, all counters 0, shift register 0.
REQ-030 Reset values: pin_rdy=0, op_ack=0 during the reset cycle then 1 in IDLE, op_commit=0, sout=0, scaning=0.
REQ-031 Reset mid-LOAD or mid-SHIFT SHALL abort without op_commit; memory contents are not cleared.
REQ-032 A val_op asserted in the same cycle as reset=0 SHALL be ignored.

Structure
REQ-033 Shared package piso_buf_pkg SHALL hold WORD_W, DEPTH defaults, state encoding and op codes (OP_LOAD=0, OP_SHIFT=1).
REQ-034 Storage SHALL be one sub-module piso_buf_256b_mem: DEPTH x WORD_W synchronous RAM, one write port, one read port, 1-cycle read latency.
REQ-035 FSM, counters and shift register SHALL live in the top module.

Verification
REQ-036 LOAD mem[i]=0x00000000+i for i=0..63 -> op_commit pulses one cycle after 64th accepted word; pin_rdy drops with it.
REQ-037 LOAD words 0xA5A5A5A5 then SHIFT -> scaning high exactly 2048 cycles starting 2 cycles after op_ack, sout = 1,0,1,0,0,1,0,1 repeating, then op_commit.
REQ-038 LOAD word0=0x00000001, word1=0x80000000, others 0, SHIFT -> sout=1 only at n=0 and n=63.
REQ-039 LOAD with pin_val toggling every other cycle -> exactly 64 writes, LOAD lasts 128 cycles, data order preserved.
REQ-040 reset=0 at SHIFT cycle n=1000 -> next cycle scaning=0, sout=0, no op_commit; subsequent SHIFT replays prior data from n=0.
REQ-041 val_op pulsed during LOAD and SHIFT -> op_ack stays 0 and the running command completes unaffected.
